// File: rtl/hamming_pkg.sv
// Hamming(15,11) shared definitions.
// Provides code geometry constants, parity positions, codeword/data types,
// the collector state type, and helpers for syndrome and data extraction.
// Codeword positions are [1:15] = {p1,p2,d1,p3,d2,d3,d4,p4,d5..d11}, even parity.
package hamming_pkg;

    localparam int unsigned CW_LEN   = 15;
    localparam int unsigned DATA_LEN = 11;
    localparam int unsigned SYN_W    = 4;

    localparam int unsigned P1_POS = 1;
    localparam int unsigned P2_POS = 2;
    localparam int unsigned P4_POS = 4;
    localparam int unsigned P8_POS = 8;

    typedef logic [1:CW_LEN]   codeword_t;
    typedef logic [1:DATA_LEN] data_t;
    typedef logic [SYN_W-1:0]  syndrome_t;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } rx_state_t;

    function automatic logic is_parity_pos(input int unsigned pos);
        return (pos == P1_POS) || (pos == P2_POS) || (pos == P4_POS) || (pos == P8_POS);
    endfunction

    // Bit k of the syndrome covers every position whose index has bit k set.
    function automatic syndrome_t hm_syndrome(input codeword_t cw);
        syndrome_t s;
        s = '0;
        for (int unsigned i = 1; i <= CW_LEN; i++) begin
            for (int unsigned k = 0; k < SYN_W; k++) begin
                if (i[k]) begin
                    s[k] = s[k] ^ cw[i];
                end
            end
        end
        return s;
    endfunction

    // Data bits occupy the non-power-of-two positions, in ascending order.
    function automatic data_t hm_extract(input codeword_t cw);
        data_t       d;
        int unsigned j;
        d = '0;
        j = 1;
        for (int unsigned i = 1; i <= CW_LEN; i++) begin
            if (!is_parity_pos(i)) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_serial_rx_if.sv
// Serial-in / valid-ready-out bundle for hamming_serial_rx.
// master: upstream channel + downstream consumer (drives ser_in, ser_valid,
//         sof, dout_ready; observes dout, dout_valid, corrected, frame_err,
//         overflow).
// slave : the receiver itself.
interface hamming_serial_rx_if;
    import hamming_pkg::*;

    logic  ser_in;
    logic  ser_valid;
    logic  sof;
    data_t dout;
    logic  dout_valid;
    logic  dout_ready;
    logic  corrected;
    logic  frame_err;
    logic  overflow;

    modport master (
        output ser_in, ser_valid, sof, dout_ready,
        input  dout, dout_valid, corrected, frame_err, overflow
    );

    modport slave (
        input  ser_in, ser_valid, sof, dout_ready,
        output dout, dout_valid, corrected, frame_err, overflow
    );

endinterface

// File: rtl/hamming_syndrome_correct.sv
// Combinational Hamming(15,11) single-error corrector.
// Ports:
//   code      in  : received codeword, positions [1:15]
//   data      out : corrected data d1..d11
//   corrected out : 1 when the syndrome was nonzero
module hamming_syndrome_correct
    import hamming_pkg::*;
(
    input  codeword_t code,
    output data_t     data,
    output logic      corrected
);

    syndrome_t syn;
    codeword_t fixed;

    always_comb begin
        syn   = hm_syndrome(code);
        fixed = code;
        // Nonzero syndrome is the index of the flipped position.
        if (syn != '0) begin
            fixed[syn] = ~fixed[syn];
        end
        data      = hm_extract(fixed);
        corrected = (syn != '0);
    end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial Hamming(15,11) receive stage.
// Collects 15 serial bits (position 1 first), checks/corrects the word one
// cycle later and holds the 11-bit result in a single-entry valid/ready slot.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : hamming_serial_rx_if.slave (ser_in, ser_valid, sof, dout,
//              dout_valid, dout_ready, corrected, frame_err, overflow)
module hamming_serial_rx
    import hamming_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    hamming_serial_rx_if.slave bus
);

    rx_state_t state, state_n;
    logic [3:0] count, count_n;
    logic       shift_en;
    logic       load_chk;
    logic       frame_err_n;

    codeword_t  shreg;
    codeword_t  chk_reg;
    logic       chk_pend;

    data_t      fix_data;
    logic       fix_corr;
    logic       slot_free;

    data_t      dout_q;
    logic       dout_valid_q;
    logic       corrected_q;
    logic       frame_err_q;
    logic       overflow_q;

    always_comb begin
        state_n     = state;
        count_n     = count;
        shift_en    = 1'b0;
        load_chk    = 1'b0;
        frame_err_n = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.ser_valid && bus.sof) begin
                    shift_en = 1'b1;
                    count_n  = 4'd1;
                    state_n  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.ser_valid) begin
                    shift_en = 1'b1;
                    if (bus.sof) begin
                        // Abort partial frame; this bit is position 1 of the next.
                        frame_err_n = 1'b1;
                        count_n     = 4'd1;
                    end else if (count == 4'(CW_LEN - 1)) begin
                        load_chk = 1'b1;
                        count_n  = '0;
                        state_n  = ST_IDLE;
                    end else begin
                        count_n = count + 4'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    hamming_syndrome_correct u_fix (
        .code      (chk_reg),
        .data      (fix_data),
        .corrected (fix_corr)
    );

    // Same-edge consume and load keeps the slot full without a bubble.
    assign slot_free = !dout_valid_q || bus.dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg        <= '0;
            chk_reg      <= '0;
            chk_pend     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            corrected_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            // Left shift: after 15 shifts position 1 lands at index 1.
            if (shift_en) begin
                shreg <= {shreg[2:CW_LEN], bus.ser_in};
            end
            if (load_chk) begin
                chk_reg <= {shreg[2:CW_LEN], bus.ser_in};
            end
            chk_pend    <= load_chk;
            frame_err_q <= frame_err_n;
            overflow_q  <= chk_pend && !slot_free;
            if (chk_pend && slot_free) begin
                dout_q       <= fix_data;
                corrected_q  <= fix_corr;
                dout_valid_q <= 1'b1;
            end else if (bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.corrected  = corrected_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Self-checking bench for hamming_serial_rx: directed scenarios with literal
// expectations plus randomized frames compared every cycle against a
// nearest-codeword behavioural model.
module tb_hamming_serial_rx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;   // 0: low, 1: high, 2: random
    bit   cmp_en = 1'b0;

    hamming_serial_rx_if bus ();

    hamming_serial_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model helpers ----------------
    // Codewords held as logic [15:0], bit i = position i (bit 0 unused).
    // Data held as logic [10:0], bit 10 = d1.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        int j;
        logic x;
        c = '0;
        j = 10;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[j];
                j--;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            x = 1'b0;
            for (int i = 1; i < 16; i++) begin
                if (((i & p) != 0) && (i != p)) x = x ^ c[i];
            end
            c[p] = x;
        end
        return c;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        logic [10:0] d;
        int j;
        d = '0;
        j = 10;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = c[i];
                j--;
            end
        end
        return d;
    endfunction

    // Perfect code: exactly one codeword lies within distance 1 of any word.
    function automatic logic [11:0] decode(input logic [15:0] c);
        logic [15:0] t;
        for (int f = 0; f < 16; f++) begin
            t = c;
            if (f != 0) t[f] = ~t[f];
            if (encode(extract(t)) == t) return {(f != 0), extract(t)};
        end
        return '0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          in_frame;
    int          nbits;
    logic [15:0] rxw;
    bit          chk_due;
    logic [11:0] chk_res;
    bit          m_valid;
    logic [10:0] m_dout;
    bit          m_corr;
    bit          m_ferr;
    bit          m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_frame = 0; nbits = 0; rxw = '0; chk_due = 0; chk_res = '0;
            m_valid = 0; m_dout = '0; m_corr = 0; m_ferr = 0; m_ovf = 0;
        end else begin
            m_ferr = 0;
            m_ovf  = 0;
            if (m_valid && bus.dout_ready) m_valid = 0;
            if (chk_due) begin
                if (!m_valid) begin
                    m_valid = 1;
                    m_dout  = chk_res[10:0];
                    m_corr  = chk_res[11];
                end else begin
                    m_ovf = 1;
                end
            end
            chk_due = 0;
            if (bus.ser_valid) begin
                if (bus.sof) begin
                    if (in_frame) m_ferr = 1;
                    in_frame = 1;
                    nbits    = 0;
                end
                if (in_frame) begin
                    rxw[nbits + 1] = bus.ser_in;
                    nbits++;
                    if (nbits == 15) begin
                        chk_res  = decode(rxw);
                        chk_due  = 1;
                        in_frame = 0;
                        nbits    = 0;
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_dout_valid", {31'b0, bus.dout_valid}, {31'b0, m_valid});
            check("m_dout", {21'b0, bus.dout}, {21'b0, m_dout});
            check("m_corrected", {31'b0, bus.corrected}, {31'b0, m_corr});
            check("m_frame_err", {31'b0, bus.frame_err}, {31'b0, m_ferr});
            check("m_overflow", {31'b0, bus.overflow}, {31'b0, m_ovf});
        end
    end

    // ---------------- ready driver ----------------
    initial begin
        bus.dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       bus.dout_ready = 1'b0;
                1:       bus.dout_ready = 1'b1;
                default: bus.dout_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b, input logic s);
        bus.ser_valid = 1'b1;
        bus.ser_in    = b;
        bus.sof       = s;
        @(posedge clk);
        #1;
        bus.ser_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.ser_in    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_range(input logic [15:0] cw, input int first, input int last, input bit gaps);
        for (int p = first; p <= last; p++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) idle($urandom_range(1, 2));
            send_bit(cw[p], (p == 1));
        end
    endtask

    task automatic check_out(input string name, input logic [10:0] d, input bit v,
                             input bit c, input bit fe, input bit ov);
        check({name, "_valid"}, {31'b0, bus.dout_valid}, {31'b0, v});
        check({name, "_dout"}, {21'b0, bus.dout}, {21'b0, d});
        check({name, "_corr"}, {31'b0, bus.corrected}, {31'b0, c});
        check({name, "_ferr"}, {31'b0, bus.frame_err}, {31'b0, fe});
        check({name, "_ovf"}, {31'b0, bus.overflow}, {31'b0, ov});
    endtask

    initial begin
        logic [15:0] cw;
        logic [10:0] d;
        int          nerr;

        bus.ser_in    = 1'b0;
        bus.ser_valid = 1'b0;
        bus.sof       = 1'b0;

        // Pin the model with hand-computed codewords.
        check("enc_zero", {16'b0, encode(11'h000)}, 32'h0000);
        check("enc_ones", {16'b0, encode(11'h7FF)}, 32'hFFFE);
        check("enc_d1", {16'b0, encode(11'h400)}, 32'h000E);
        check("dec_pos5", {20'b0, decode(16'hFFFE ^ 16'h0020)}, 32'hFFF);

        #1 rst = 1'b1;
        #20 rst = 1'b0;
        @(posedge clk);
        #1;
        check_out("reset", 11'h000, 0, 0, 0, 0);
        cmp_en = 1'b1;
        ready_mode = 1;
        idle(2);

        // All zeros.
        send_range(16'h0000, 1, 15, 0);
        check_out("zero_pre", 11'h000, 0, 0, 0, 0);
        idle(1);
        check_out("zero", 11'h000, 1, 0, 0, 0);
        idle(2);

        // All ones with position 5 flipped.
        send_range(16'hFFFE ^ 16'h0020, 1, 15, 0);
        idle(1);
        check_out("pos5", 11'h7FF, 1, 1, 0, 0);
        idle(2);

        // Zero codeword with parity position 8 flipped.
        send_range(16'h0100, 1, 15, 0);
        idle(1);
        check_out("pos8", 11'h000, 1, 1, 0, 0);
        idle(2);

        // Early sof at bit 9.
        send_range(encode(11'h2A5), 1, 8, 0);
        send_range(16'hFFFE, 1, 1, 0);
        check("early_ferr", {31'b0, bus.frame_err}, 32'd1);
        send_range(16'hFFFE, 2, 15, 0);
        idle(1);
        check_out("early", 11'h7FF, 1, 0, 0, 0);
        idle(2);

        // Overflow with stalled consumer, then same-edge consume+load.
        ready_mode = 0;
        idle(2);
        send_range(encode(11'h123), 1, 15, 0);
        send_range(encode(11'h456), 1, 15, 0);
        idle(1);
        check_out("ovf", 11'h123, 1, 0, 0, 1);
        send_range(encode(11'h2AA), 1, 15, 0);
        ready_mode = 1;
        idle(1);
        check_out("ovf_load", 11'h2AA, 1, 0, 0, 0);
        idle(2);

        // Reset mid-frame with a word pending.
        ready_mode = 0;
        idle(2);
        send_range(encode(11'h5A5), 1, 15, 0);
        idle(2);
        check("pend_valid", {31'b0, bus.dout_valid}, 32'd1);
        send_range(encode(11'h0F0), 1, 7, 0);
        rst = 1'b1;
        #1;
        check_out("rst_mid", 11'h000, 0, 0, 0, 0);
        #3 rst = 1'b0;
        ready_mode = 1;
        idle(1);
        send_range(16'h0000, 1, 15, 0);
        idle(1);
        check_out("post_rst", 11'h000, 1, 0, 0, 0);
        idle(2);

        // Randomized frames; the per-cycle compare process does the checking.
        ready_mode = 2;
        for (int n = 0; n < 120; n++) begin
            d    = 11'($urandom_range(0, 2047));
            cw   = encode(d);
            nerr = $urandom_range(0, 2);
            for (int e = 0; e < nerr; e++) cw[$urandom_range(1, 15)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                send_range(16'($urandom), 1, $urandom_range(1, 14), 1);
            end
            if ($urandom_range(0, 5) == 0) send_bit(1'($urandom_range(0, 1)), 1'b0);
            send_range(cw, 1, 15, 1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        ready_mode = 1;
        idle(6);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hamming_serial_rx.md
# hamming_serial_rx

Serial receive stage for the Hamming(15,11) link. It collects a bit-serial 15-bit codeword, computes the 4-bit syndrome and corrects any single-bit error. It then presents the 11-bit data word on a valid/ready output. It sits directly downstream of the channel fed by the HE encoder and replaces the purely combinational HD decode path in the streaming datapath.

## Interface
- `N`, 15: codeword length; only legal value.
- `K`, 11: data length; only legal value.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `ser_in` input 1: serial codeword bit.
- `ser_valid` input 1: `ser_in` is sampled on this edge.
- `sof` input 1: qualified by `ser_valid`; marks codeword position 1.
- `dout` output [1:11]: corrected data `d1..d11`.
- `dout_valid` output 1: `dout` holds an unconsumed word.
- `dout_ready` input 1: consumer accepts `dout` on this edge.
- `corrected` output 1: nonzero syndrome on the word in `dout`; valid with `dout_valid`.
- `frame_err` output 1: 1-cycle pulse when a frame is aborted by an early `sof`.
- `overflow` output 1: 1-cycle pulse when a completed frame is dropped.

## Operation
- **Codeword layout.** Positions `[1:15]` are `{p1,p2,d1,p3,d2,d3,d4,p4,d5..d11}`. Parity bits sit at positions 1, 2, 4 and 8. Even parity is used.
- **Bit order.** Bits arrive in position order, position 1 first.
- **Collector FSM.**
  - `IDLE`: `ser_valid & ~sof` is ignored. `ser_valid & sof` stores the bit as position 1, sets count=1 and moves to `SHIFT`.
  - `SHIFT`: each `ser_valid` stores the next position and increments count.
  - On the edge that stores position 15: copy the word to the check register, set `chk_pend`, return to `IDLE`. Count restarts at 0; it never wraps past 15.
  - `SHIFT` with `ser_valid & sof`: discard the partial frame, pulse `frame_err`, and take this bit as position 1 of a new frame (stay in `SHIFT`, count=1).
- **Check stage.** Occupies the cycle after `chk_pend` is set.
  - Syndrome bit k (k=0..3) = XOR of code[i] over every i in 1..15 with bit k of i set.
  - Syndrome s≠0: invert position s, set `corrected`=1.
  - Syndrome s=0: no change, `corrected`=0.
  - Extract `d1..d11` from positions 3, 5, 6, 7, 9..15.
  - Double errors are miscorrected silently; this is inherent to the code and not flagged.
- **Output slot.** Single-entry register.
  - Load on the check edge if the slot is empty, or if `dout_valid & dout_ready` on that same edge (same-edge consume and load is allowed, no bubble).
  - Otherwise drop the checked word, pulse `overflow`, and leave `dout` unchanged.
  - `dout_valid` stays high until `dout_ready`. `dout` and `corrected` stay stable while `dout_valid` is high.
- **Back-to-back frames.** `sof` for the next frame is accepted on the cycle immediately after position 15.
- **Reset.** Async assertion at any point, mid-frame or with `dout` pending: return to `IDLE`, count=0, `chk_pend`=0. All outputs clear: `dout`=0, `dout_valid`=0, `corrected`=0, `frame_err`=0, `overflow`=0. The partial frame is lost.

## Timing
- **Latency.** Position 15 is sampled at edge T. `dout_valid` is visible after edge T+1 (check edge).
- **Throughput.** One codeword per 15 `ser_valid` cycles. The collector never stalls.
- **Pulse timing.**
  - `frame_err` is high for the cycle after the offending edge.
  - `overflow` is high for the cycle after the check edge.
- **Output path.** All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Package `hamming_pkg`:** `CW_LEN`=15, `DATA_LEN`=11, `SYN_W`=4; the parity-position constants; typedefs `codeword_t` `[1:15]` and `data_t` `[1:11]`; functions `hm_syndrome(codeword_t)` and `hm_extract(codeword_t)`.
- **Sub-module `hamming_syndrome_correct`:** purely combinational; codeword in, corrected data and `corrected` out. It is shared with the parallel decoder path.
- **Top-level contents:** collector FSM, check register and output slot.

## Test plan
- **All zeros.** `sof` + 15 zero bits, `dout_ready`=1 → `dout`=11'h000, `corrected`=0, `dout_valid` one cycle after bit 15.
- **Position 5 error.** Codeword all ones with position 5 flipped → syndrome 5, `dout`=11'h7FF, `corrected`=1.
- **Parity-bit error.** All-zero codeword with position 8 flipped → `dout`=11'h000, `corrected`=1.
- **Early `sof`.** `sof` at bit 9 of a frame → `frame_err` pulse. A new all-ones frame starting at that bit yields `dout`=11'h7FF with no further flags.
- **Overflow.** `dout_ready`=0 for two back-to-back frames → first word held, `overflow` pulses at the second check edge. Then with `dout_ready`=1 on a check edge, the next word loads with no gap and no `overflow`.
- **Reset mid-frame.** `rst` asserted after bit 7 with a word pending in `dout` → all outputs 0 immediately. A fresh all-zeros frame afterward decodes normally.
